// File: rtl/pwm_motor_drive.sv
// rtl/pwm_motor_drive.sv - sign-magnitude PWM driver for one H-bridge channel
// Commands are captured on a strobe and applied only at period boundaries.
module pwm_motor_drive #(
   parameter int W        = 15,
   parameter int PB       = 10,
   parameter int PERIOD   = 1000,
   parameter int MAX_DUTY = 950,
   parameter int DEADTIME = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W:0]    u_in,
   input  logic          u_valid,
   input  logic          enable,
   output logic          pwm_a,
   output logic          pwm_b,
   output logic          dir,
   output logic [PB-1:0] duty,
   output logic          sat,
   output logic          period_start
);

   localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam int CW = (W + 1 > 32) ? W + 1 : 32;
   localparam logic [CW-1:0] MAXW  = CW'(MAX_DUTY);
   localparam logic [PB-1:0] MAXD  = PB'(MAX_DUTY);
   localparam logic [PB-1:0] LAST  = PB'(PERIOD - 1);
   localparam logic [DW-1:0] DLAST = DW'(DEADTIME - 1);

   typedef enum logic {DRIVE, DEAD} state_t;

   state_t        state, state_n;
   logic [PB-1:0] cnt, cnt_n, cnt_inc, duty_n, eff;
   logic [W:0]    pending, pending_n, mag;
   logic [CW-1:0] magw;
   logic [DW-1:0] deadcnt, deadcnt_n;
   logic          dir_n, sat_n, pwm_a_n, pwm_b_n, ps_n;
   logic          over, reverse, active, at_last;

   // Unsigned magnitude in W+1 bits, so the most negative command maps to 2^W.
   always_comb begin
      mag     = pending[W] ? -pending : pending;
      magw    = CW'(mag);
      over    = magw > MAXW;
      eff     = over ? MAXD : magw[PB-1:0];
      reverse = (|pending) && (pending[W] != dir);
      active  = cnt < duty;
      at_last = cnt == LAST;
      cnt_inc = at_last ? '0 : cnt + 1'b1;
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      duty_n    = duty;
      dir_n     = dir;
      sat_n     = sat;
      deadcnt_n = deadcnt;
      pending_n = u_valid ? u_in : pending;
      pwm_a_n   = 1'b0;
      pwm_b_n   = 1'b0;
      ps_n      = (state == DRIVE) && (cnt == '0);
      if (!enable) begin
         state_n   = DRIVE;
         cnt_n     = cnt_inc;
         duty_n    = '0;
         sat_n     = 1'b0;
         deadcnt_n = '0;
      end else begin
         case (state)
            DRIVE: begin
               pwm_a_n = active & ~dir;
               pwm_b_n = active & dir;
               cnt_n   = cnt_inc;
               if (at_last) begin
                  if (reverse) begin
                     state_n   = DEAD;
                     duty_n    = '0;
                     deadcnt_n = '0;
                  end else begin
                     duty_n = eff;
                     sat_n  = over;
                  end
               end
            end
            DEAD: begin
               cnt_n     = '0;
               deadcnt_n = deadcnt + 1'b1;
               // Pending is re-evaluated here; a cancelled reversal keeps dir.
               if (deadcnt == DLAST) begin
                  state_n = DRIVE;
                  if (reverse) dir_n = ~dir;
                  duty_n = eff;
                  sat_n  = over;
               end
            end
            default: state_n = DRIVE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= DRIVE;
         cnt          <= '0;
         pending      <= '0;
         deadcnt      <= '0;
         duty         <= '0;
         dir          <= 1'b0;
         sat          <= 1'b0;
         pwm_a        <= 1'b0;
         pwm_b        <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         pending      <= pending_n;
         deadcnt      <= deadcnt_n;
         duty         <= duty_n;
         dir          <= dir_n;
         sat          <= sat_n;
         pwm_a        <= pwm_a_n;
         pwm_b        <= pwm_b_n;
         period_start <= ps_n;
      end
   end

endmodule
